// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: wraps a 32-bit MAC frame stream with Start/preamble/SFD,
// Terminate and inter-packet gap, keeping Start on the first transfer of each 64-bit block.
module xgmii_tx_framer #(
    parameter int W_DATA        = 32,
    parameter int MIN_IPG_XFERS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [W_DATA-1:0]     s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic [W_DATA/8-1:0]   s_keep,
    output logic                  s_ready,
    output logic [W_DATA-1:0]     o_txd,
    output logic [W_DATA/8-1:0]   o_txc,
    output logic                  o_blk_sof,
    output logic                  o_err_underrun
);
    localparam int NL = W_DATA / 8;
    localparam int KW = $clog2(NL) + 1;
    localparam int CW = (MIN_IPG_XFERS > 2) ? $clog2(MIN_IPG_XFERS) : 1;
    localparam logic [CW-1:0] IPG_LAST = CW'(MIN_IPG_XFERS - 1);

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;
    localparam logic [7:0] C_PRE   = 8'h55;
    localparam logic [7:0] C_SFD   = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_TERM, S_IPG, S_DROP
    } state_t;

    // With a zero gap the framer may re-arm directly after Terminate.
    localparam state_t S_AFTER_TERM = (MIN_IPG_XFERS == 0) ? S_IDLE : S_IPG;

    state_t            state_q, state_d;
    logic [W_DATA-1:0] txd_q, txd_d;
    logic [NL-1:0]     txc_q, txc_d;
    logic              s_ready_q, s_ready_d;
    logic              blk_sof_q, blk_sof_d;
    logic              sof_nxt_q, sof_nxt_d;
    logic              err_q, err_d;
    logic [CW-1:0]     ipg_cnt_q, ipg_cnt_d;

    logic [KW-1:0]     keep_cnt;
    logic [W_DATA-1:0] term_txd;
    logic [NL-1:0]     term_txc;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < NL; i++) begin
            keep_cnt = keep_cnt + KW'(s_keep[i]);
        end
    end

    // Terminate lands right after the last valid byte; popcount keeps it framed even for sparse masks.
    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_term_lane
            assign term_txd[8*gi +: 8] = (KW'(gi) < keep_cnt)  ? s_data[8*gi +: 8] :
                                         (KW'(gi) == keep_cnt) ? C_TERM : C_IDLE;
            assign term_txc[gi]        = (KW'(gi) >= keep_cnt);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        txd_d     = {NL{C_IDLE}};
        txc_d     = '1;
        s_ready_d = 1'b0;
        err_d     = 1'b0;
        ipg_cnt_d = ipg_cnt_q;
        blk_sof_d = sof_nxt_q;
        sof_nxt_d = ~sof_nxt_q;

        unique case (state_q)
            S_IDLE: begin
                if (s_valid && sof_nxt_q) begin
                    txd_d   = {C_PRE, C_PRE, C_PRE, C_START};
                    txc_d   = 4'b0001;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                txd_d     = {C_SFD, C_PRE, C_PRE, C_PRE};
                txc_d     = '0;
                s_ready_d = 1'b1;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (s_valid && s_ready_q) begin
                    if (!s_last) begin
                        txd_d     = s_data;
                        txc_d     = '0;
                        s_ready_d = 1'b1;
                    end else if (keep_cnt == KW'(NL)) begin
                        txd_d   = s_data;
                        txc_d   = '0;
                        state_d = S_TERM;
                    end else begin
                        txd_d     = term_txd;
                        txc_d     = term_txc;
                        ipg_cnt_d = '0;
                        state_d   = S_AFTER_TERM;
                    end
                end else begin
                    txd_d     = {NL{C_ERR}};
                    err_d     = 1'b1;
                    s_ready_d = 1'b1;
                    state_d   = S_DROP;
                end
            end
            S_TERM: begin
                txd_d     = {C_IDLE, C_IDLE, C_IDLE, C_TERM};
                ipg_cnt_d = '0;
                state_d   = S_AFTER_TERM;
            end
            S_IPG: begin
                if (ipg_cnt_q == IPG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ipg_cnt_d = ipg_cnt_q + 1'b1;
                end
            end
            S_DROP: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q && s_last) begin
                    s_ready_d = 1'b0;
                    ipg_cnt_d = '0;
                    state_d   = S_AFTER_TERM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            txd_q     <= {NL{C_IDLE}};
            txc_q     <= '1;
            s_ready_q <= 1'b0;
            blk_sof_q <= 1'b0;
            sof_nxt_q <= 1'b1;
            err_q     <= 1'b0;
            ipg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            txc_q     <= txc_d;
            s_ready_q <= s_ready_d;
            blk_sof_q <= blk_sof_d;
            sof_nxt_q <= sof_nxt_d;
            err_q     <= err_d;
            ipg_cnt_q <= ipg_cnt_d;
        end
    end

    assign s_ready        = s_ready_q;
    assign o_txd          = txd_q;
    assign o_txc          = txc_q;
    assign o_blk_sof      = blk_sof_q;
    assign o_err_underrun = err_q;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Bench for xgmii_tx_framer: a frame-level timeline model predicts every output cycle,
// plus literal expectations for start, preamble, terminate, error and reset transfers.
module tb_xgmii_tx_framer;
    localparam int MIN_IPG = 3;
    localparam int HOR     = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [3:0]  s_keep = '0;
    logic        s_ready;
    logic [31:0] o_txd;
    logic [3:0]  o_txc;
    logic        o_blk_sof;
    logic        o_err_underrun;

    always #5 clk = ~clk;

    xgmii_tx_framer #(.W_DATA(32), .MIN_IPG_XFERS(MIN_IPG)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_keep         (s_keep),
        .s_ready        (s_ready),
        .o_txd          (o_txd),
        .o_txc          (o_txc),
        .o_blk_sof      (o_blk_sof),
        .o_err_underrun (o_err_underrun)
    );

    int checks = 0;
    int failures = 0;
    int cyc = -1;
    int prev_free = 0;
    int last_s = 0;
    int last_t = 0;

    logic [31:0] exp_txd [HOR];
    logic [3:0]  exp_txc [HOR];
    logic        exp_rdy [HOR];
    logic        exp_err [HOR];
    logic [31:0] obs_txd [HOR];
    logic [3:0]  obs_txc [HOR];
    logic        obs_sof [HOR];
    logic        obs_err [HOR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] beat_word(input logic [7:0] base, input int j);
        logic [7:0] b;
        b = base + 8'(4 * j);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic put(input int n, input logic [31:0] d, input logic [3:0] c);
        if (n >= 0 && n < HOR) begin
            exp_txd[n] = d;
            exp_txc[n] = c;
        end
    endtask

    task automatic set_rdy(input int from, input int to);
        for (int n = from; n <= to; n++) if (n < HOR) exp_rdy[n] = 1'b1;
    endtask

    task automatic model_clear();
        for (int n = 0; n < HOR; n++) begin
            exp_txd[n] = 32'h07070707;
            exp_txc[n] = 4'hF;
            exp_rdy[n] = 1'b0;
            exp_err[n] = 1'b0;
        end
        prev_free = 0;
    endtask

    // Frame timeline: Start at first even cycle once valid and the gap allow it.
    task automatic model_add(input int nb, input logic [7:0] base, input logic [3:0] keep,
                             input int u, input int v);
        int s, t, k;
        logic [31:0] w, tw;
        logic [3:0]  tc;
        s = (v > prev_free) ? v : prev_free;
        if (s % 2 != 0) s++;
        put(s, 32'h555555FB, 4'h1);
        put(s + 1, 32'hD5555555, 4'h0);
        if (u >= 0) begin
            for (int j = 0; j < u; j++) put(s + 2 + j, beat_word(base, j), 4'h0);
            put(s + 2 + u, 32'hFEFEFEFE, 4'hF);
            if (s + 2 + u < HOR) exp_err[s + 2 + u] = 1'b1;
            t = s + 2 + u + (nb - u);
            set_rdy(s + 1, t - 1);
        end else begin
            for (int j = 0; j < nb - 1; j++) put(s + 2 + j, beat_word(base, j), 4'h0);
            w = beat_word(base, nb - 1);
            k = $countones(keep);
            if (k == 4) begin
                put(s + nb + 1, w, 4'h0);
                t = s + nb + 2;
                put(t, 32'h070707FD, 4'hF);
            end else begin
                for (int l = 0; l < 4; l++) begin
                    tw[8*l +: 8] = (l < k) ? w[8*l +: 8] : ((l == k) ? 8'hFD : 8'h07);
                    tc[l] = (l >= k);
                end
                t = s + nb + 1;
                put(t, tw, tc);
            end
            set_rdy(s + 1, s + nb);
        end
        prev_free = t + MIN_IPG + 1;
        last_s = s;
        last_t = t;
    endtask

    always @(posedge clk) begin
        if (!rst_n) cyc = -1;
        else cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < HOR) begin
            obs_txd[cyc] = o_txd;
            obs_txc[cyc] = o_txc;
            obs_sof[cyc] = o_blk_sof;
            obs_err[cyc] = o_err_underrun;
            chk($sformatf("cyc%0d{txd,txc,sof,rdy,err}", cyc),
                {o_txd, o_txc, o_blk_sof, s_ready, o_err_underrun},
                {exp_txd[cyc], exp_txc[cyc], (cyc % 2 == 0), exp_rdy[cyc], exp_err[cyc]});
        end
    end

    task automatic send_frame(input int nb, input logic [7:0] base, input logic [3:0] keep,
                              input int u, input int abort);
        int j = 0;
        int guard = 0;
        bit paused = 0;
        bit first = 1;
        while (j < nb && !(abort > 0 && j >= abort)) begin
            @(negedge clk);
            if (first) begin
                model_add(nb, base, keep, u, cyc + 1);
                first = 0;
            end
            if (j == u && !paused && s_ready) begin
                s_valid = 1'b0;
                paused = 1;
            end else begin
                s_valid = 1'b1;
                s_data  = beat_word(base, j);
                s_last  = (j == nb - 1);
                s_keep  = (j == nb - 1) ? keep : 4'hF;
                if (s_ready) j++;
            end
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=%0d required=%0d beats", j, nb);
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_txd"}, o_txd, 32'h07070707);
        chk({tag, "_txc"}, o_txc, 4'hF);
        chk({tag, "_ready"}, s_ready, 1'b0);
        chk({tag, "_sof"}, o_blk_sof, 1'b0);
        chk({tag, "_err"}, o_err_underrun, 1'b0);
    endtask

    logic [3:0]  kc_keep [4];
    logic [31:0] kc_txd  [4];
    logic [3:0]  kc_txc  [4];
    logic [3:0]  sw_keep [6];
    int          sw_s    [6];
    int          t4, fe;

    initial begin
        kc_keep = '{4'h0, 4'h1, 4'h3, 4'h7};
        kc_txd  = '{32'h070707FD, 32'h0707FD40, 32'h07FD4140, 32'hFD424140};
        kc_txc  = '{4'hF, 4'hE, 4'hC, 4'h8};
        sw_keep = '{4'hF, 4'h1, 4'h3, 4'h7, 4'h0, 4'hF};

        model_clear();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // 4 beats, last keep 0111
        send_frame(4, 8'h10, 4'b0111, -1, 0);
        idle_cycles(12);
        chk("t1_model_term_cycle", last_t, 7);
        chk("t1_model_term_txd", exp_txd[7], 32'hFD1E1D1C);
        chk("t1_start_txd", obs_txd[2], 32'h555555FB);
        chk("t1_start_txc", obs_txc[2], 4'h1);
        chk("t1_start_sof", obs_sof[2], 1'b1);
        chk("t1_pre_txd", {obs_txd[3], obs_txc[3]}, {32'hD5555555, 4'h0});
        chk("t1_term_txd", {obs_txd[7], obs_txc[7]}, {32'hFD1E1D1C, 4'h8});
        for (int i = 8; i <= 10; i++)
            chk($sformatf("t1_ipg%0d", i), {obs_txd[i], obs_txc[i]}, {32'h07070707, 4'hF});

        // full last beat: separate Terminate transfer
        send_frame(2, 8'h20, 4'hF, -1, 0);
        t4 = last_t;
        idle_cycles(10);
        chk("k4_last_data", {obs_txd[t4 - 1], obs_txc[t4 - 1]}, {32'h27262524, 4'h0});
        chk("k4_term", {obs_txd[t4], obs_txc[t4]}, {32'h070707FD, 4'hF});

        // k = 0..3 Terminate position
        for (int i = 0; i < 4; i++) begin
            send_frame(1, 8'h40, kc_keep[i], -1, 0);
            t4 = last_t;
            idle_cycles(8);
            chk($sformatf("k%0d_term", $countones(kc_keep[i])),
                {obs_txd[t4], obs_txc[t4]}, {kc_txd[i], kc_txc[i]});
        end

        // back-to-back sweep, both alignment parities
        for (int len = 1; len <= 6; len++) begin
            send_frame(len, 8'(8'h80 + 16 * len), sw_keep[len - 1], -1, 0);
            sw_s[len - 1] = last_s;
        end
        idle_cycles(12);
        for (int i = 0; i < 6; i++)
            chk($sformatf("b2b_start%0d", i + 1), {obs_txd[sw_s[i]], obs_sof[sw_s[i]]},
                {32'h555555FB, 1'b1});

        // underrun in beat 2 of 5, then a normal frame
        send_frame(5, 8'hC0, 4'hF, 2, 0);
        fe = last_s + 4;
        send_frame(3, 8'hD0, 4'b0011, -1, 0);
        idle_cycles(12);
        chk("underrun_fe", {obs_txd[fe], obs_txc[fe], obs_err[fe]}, {32'hFEFEFEFE, 4'hF, 1'b1});

        // reset in the middle of DATA
        send_frame(6, 8'hE0, 4'hF, -1, 3);
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(2, 8'hF0, 4'b0001, -1, 0);
        idle_cycles(10);
        chk("post_reset_start", {obs_txd[2], obs_sof[2]}, {32'h555555FB, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xgmii_tx_framer.md
# xgmii_tx_framer

Transmit-side framer between the MAC payload source and the 64b/66b PCS encoder. It takes a 32-bit frame stream (FCS already appended) and produces a continuous 32-bit XGMII transmit stream of data and control lanes, using the shared symbol and block constants. Each frame gets a Start character, the preamble and SFD, a Terminate character and a minimum inter-packet gap. Start is aligned to the first transfer of a 64-bit PCS block, so the downstream encoder never sees Start in lane 4.

## Interface
Parameters:
- W_DATA, default 32 (from common params): transfer width. Only 32 is supported; 4 lanes, lane 0 = bits [7:0].
- MIN_IPG_XFERS, default 3: minimum number of all-idle transfers after the transfer carrying Terminate or Error.

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_rst_n  in  1  reset. Synchronous, active-low.
- s_data  in  32  payload bytes; lane 0 is the first byte on the wire.
- s_valid  in  1  payload beat valid.
- s_last  in  1  last beat of the frame.
- s_keep  in  4  valid-lane mask, only meaningful with s_last. Contiguous from lane 0.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- o_txd  out  32  XGMII transmit data.
- o_txc  out  4  XGMII control flags; bit n = 1 means lane n carries a control symbol.
- o_blk_sof  out  1  high on the first transfer of each 64-bit block.
- o_err_underrun  out  1  one-cycle pulse when a frame is aborted.

## Operation
- All outputs are registered.
- Reset values:
  - o_txd = 32'h07070707 and o_txc = 4'hF.
  - s_ready = 0, o_blk_sof = 0, o_err_underrun = 0.
  - The IPG requirement counts as already satisfied.
  - Phase is set so that the first transfer after reset release has o_blk_sof = 1.
- o_blk_sof alternates 1,0,1,0… every cycle after reset, independent of framing.
- States: IDLE, PREAMBLE, DATA, TERM, IPG, DROP.
- IDLE:
  - Drives idle transfers (07 in all lanes, txc = F).
  - When s_valid = 1 and the next output transfer has o_blk_sof = 1, it emits the Start transfer, lanes 0..3 = FB 55 55 55 with txc = 4'b0001, and goes to PREAMBLE.
  - Otherwise it waits one cycle. s_ready = 0.
- PREAMBLE:
  - Emits 55 55 55 D5 with txc = 0 and goes to DATA.
- DATA:
  - s_ready = 1. Each accepted non-last beat is emitted unchanged with txc = 0.
  - Accepted last beat with k = popcount(s_keep):
    - k < 4: lanes below k carry data; lane k carries FD; lanes above k carry 07; txc = the lanes ≥ k. Go to IPG.
    - k = 4: emit all data with txc = 0 and go to TERM.
    - s_keep = 0 gives FD in lane 0.
  - s_valid = 0 (underrun):
    - Emit FE in all lanes with txc = F.
    - Pulse o_err_underrun.
    - Go to DROP.
- TERM: emits FD 07 07 07 with txc = F and goes to IPG.
- IPG:
  - Emits idles and counts MIN_IPG_XFERS transfers, then goes to IDLE.
  - Block-alignment wait happens in IDLE and is added on top of the gap.
- DROP:
  - s_ready = 1. Emits idles and discards beats until a beat with s_last is accepted.
  - Then it clears the IPG counter and goes to IPG.
- Non-contiguous s_keep is illegal: behaviour is undefined, but the framer must stay framed (Terminate always emitted).
- Reset asserted mid-frame: the next output is idle. No Terminate is emitted and the partial frame is abandoned.

## Timing
- s_valid sampled high in IDLE at edge E0 with an aligned slot:
  - Start transfer on the outputs after E0.
  - Preamble transfer after E1.
  - s_ready high in the cycle after E1; first payload on o_txd after E2.
  - Misaligned slot: everything shifts by exactly one cycle.
- Payload latency from acceptance to o_txd is 1 cycle. Throughput is 1 beat per cycle with no bubbles allowed inside a frame.
- Back-to-back frames, k = 4 case:
  - The last data beat is followed by the TERM transfer, then MIN_IPG_XFERS idles, then Start at the next aligned slot.
  - Minimum Start-to-Start spacing = frame beats + 2 + 1 + MIN_IPG_XFERS, rounded up to even.
- o_err_underrun is high in the same cycle the FE transfer is on o_txd.

## Test plan
- Single frame, 4 beats, last s_keep = 4'b0111:
  - Outputs: FB555555/0001, 55555555-D5/0000, 4 data transfers.
  - The last data transfer carries FD in lane 3 with txc = 1000, followed by exactly 3 idle transfers.
  - Start has o_blk_sof = 1.
- Last s_keep = 4'hF: a separate FD070707/1111 transfer follows the data. Then check each case k = 0..3 for FD position and the txc mask.
- Back-to-back frames with s_valid held high: the gap is ≥ 3 idle transfers and the next Start always lands where o_blk_sof = 1.
  - Sweep frame lengths 1..6 to hit both alignment parities.
- Underrun: drop s_valid in beat 2 of 5.
  - Outputs: an FEFEFEFE/1111 transfer and an o_err_underrun pulse.
  - The remaining beats are accepted and discarded, then 3 idles, then the next frame is normal.
- Reset mid-DATA: o_txd = 07070707 / txc = F and s_ready = 0 on the first cycle after reset. A new frame starts cleanly at the first aligned slot.
